// File: rtl/async_ram_ctrl_if.sv
// async_ram_ctrl_if: command and RAM bus bundle for async_ram_ctrl.
//   Command side : i_req, i_we, i_addr, i_wdata -> o_ready, o_rdata, o_rvalid, o_wdone
//   RAM side     : o_ramAddress, o_ramWriteNEn, o_ramWriteData, o_ramNoe, i_ramReadData
// Modports:
//   slave  - the controller (consumes commands, drives the RAM pins)
//   master - the environment (CPU memory stage plus RAM/transmitter)
interface async_ram_ctrl_if;
    logic        i_req;
    logic        i_we;
    logic [15:0] i_addr;
    logic [15:0] i_wdata;
    logic        o_ready;
    logic [15:0] o_rdata;
    logic        o_rvalid;
    logic        o_wdone;
    logic [15:0] o_ramAddress;
    logic        o_ramWriteNEn;
    logic [15:0] o_ramWriteData;
    logic [15:0] i_ramReadData;
    logic        o_ramNoe;

    modport slave (
        input  i_req, i_we, i_addr, i_wdata, i_ramReadData,
        output o_ready, o_rdata, o_rvalid, o_wdone,
               o_ramAddress, o_ramWriteNEn, o_ramWriteData, o_ramNoe
    );

    modport master (
        output i_req, i_we, i_addr, i_wdata, i_ramReadData,
        input  o_ready, o_rdata, o_rvalid, o_wdone,
               o_ramAddress, o_ramWriteNEn, o_ramWriteData, o_ramNoe
    );
endinterface

// File: rtl/async_ram_ctrl.sv
// async_ram_ctrl: synchronous initiator for an asynchronous 16x64K RAM.
// Turns req/ready commands into sequenced RAM cycles:
//   write: setup -> write-enable pulse -> hold, then o_wdone pulse
//   read : output enable low for READ_WAIT_CYCLES, then capture, o_rvalid pulse
// Ports:
//   i_clk   - clock, rising edge
//   i_reset - synchronous active-high reset
//   bus     - async_ram_ctrl_if.slave (command and RAM pins, all outputs registered)
// Optional feature: define ASYNC_RAM_CTRL_REQ_BUF_EN for a one-entry command
// buffer so a command can be accepted while a transaction is in progress.
module async_ram_ctrl #(
    parameter int SETUP_CYCLES       = 1,
    parameter int WRITE_PULSE_CYCLES = 1,
    parameter int HOLD_CYCLES        = 1,
    parameter int READ_WAIT_CYCLES   = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    async_ram_ctrl_if.slave   bus
);

    if (SETUP_CYCLES < 1 || WRITE_PULSE_CYCLES < 1 ||
        HOLD_CYCLES < 1 || READ_WAIT_CYCLES < 1) begin : g_param_err
        $error("async_ram_ctrl: all cycle parameters must be >= 1");
    end

    localparam int MAX_A = (SETUP_CYCLES > WRITE_PULSE_CYCLES) ? SETUP_CYCLES : WRITE_PULSE_CYCLES;
    localparam int MAX_B = (HOLD_CYCLES > READ_WAIT_CYCLES) ? HOLD_CYCLES : READ_WAIT_CYCLES;
    localparam int MAX_P = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    // Counter holds (cycles - 1), so MAX_P values need clog2(MAX_P) bits.
    localparam int CW    = (MAX_P > 1) ? $clog2(MAX_P) : 1;

    typedef enum logic [2:0] {IDLE, W_SETUP, W_PULSE, W_HOLD, R_WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ready_q, ready_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          wdone_q, wdone_d;
    logic [15:0]   addr_q, addr_d;
    logic          wen_q, wen_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          noe_q, noe_d;

    logic          accept;
    logic          done;
    logic          st;
    logic          st_we;
    logic [15:0]   st_addr;
    logic [15:0]   st_wdata;

`ifdef ASYNC_RAM_CTRL_REQ_BUF_EN
    logic          buf_vld_q, buf_vld_d;
    logic          buf_we_q, buf_we_d;
    logic [15:0]   buf_addr_q, buf_addr_d;
    logic [15:0]   buf_wdata_q, buf_wdata_d;
`endif

    assign accept = bus.i_req && ready_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        wdone_d  = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wen_d    = 1'b1;
        noe_d    = 1'b1;
        done     = 1'b0;
        st       = 1'b0;
        st_we    = bus.i_we;
        st_addr  = bus.i_addr;
        st_wdata = bus.i_wdata;
`ifdef ASYNC_RAM_CTRL_REQ_BUF_EN
        buf_vld_d   = buf_vld_q;
        buf_we_d    = buf_we_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
`endif

        // Sequencing of the active transaction
        case (state_q)
            W_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = W_PULSE;
                    cnt_d   = CW'(WRITE_PULSE_CYCLES - 1);
                    wen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            W_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = W_HOLD;
                    cnt_d   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    wen_d = 1'b0;
                end
            end
            W_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    wdone_d = 1'b1;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            R_WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = IDLE;
                    rdata_d  = bus.i_ramReadData;
                    rvalid_d = 1'b1;
                    done     = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    noe_d = 1'b0;
                end
            end
            default: ;
        endcase

        // Command selection: a buffered command always goes before a new one
`ifdef ASYNC_RAM_CTRL_REQ_BUF_EN
        if (done && buf_vld_q) begin
            st        = 1'b1;
            st_we     = buf_we_q;
            st_addr   = buf_addr_q;
            st_wdata  = buf_wdata_q;
            buf_vld_d = 1'b0;
        end else if (accept && (state_q == IDLE || done)) begin
            st = 1'b1;
        end else if (accept) begin
            buf_vld_d   = 1'b1;
            buf_we_d    = bus.i_we;
            buf_addr_d  = bus.i_addr;
            buf_wdata_d = bus.i_wdata;
        end
`else
        if (accept && (state_q == IDLE || done)) begin
            st = 1'b1;
        end
`endif

        if (st) begin
            addr_d  = st_addr;
            wdata_d = st_wdata;
            if (st_we) begin
                state_d = W_SETUP;
                cnt_d   = CW'(SETUP_CYCLES - 1);
            end else begin
                state_d = R_WAIT;
                cnt_d   = CW'(READ_WAIT_CYCLES - 1);
                noe_d   = 1'b0;
            end
        end

`ifdef ASYNC_RAM_CTRL_REQ_BUF_EN
        ready_d = !buf_vld_d;
`else
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            wdone_q  <= 1'b0;
            addr_q   <= '0;
            wen_q    <= 1'b1;
            wdata_q  <= '0;
            noe_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            wdone_q  <= wdone_d;
            addr_q   <= addr_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            noe_q    <= noe_d;
        end
    end

`ifdef ASYNC_RAM_CTRL_REQ_BUF_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf_vld_q   <= 1'b0;
            buf_we_q    <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
        end else begin
            buf_vld_q   <= buf_vld_d;
            buf_we_q    <= buf_we_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
        end
    end
`endif

    assign bus.o_ready        = ready_q;
    assign bus.o_rdata        = rdata_q;
    assign bus.o_rvalid       = rvalid_q;
    assign bus.o_wdone        = wdone_q;
    assign bus.o_ramAddress   = addr_q;
    assign bus.o_ramWriteNEn  = wen_q;
    assign bus.o_ramWriteData = wdata_q;
    assign bus.o_ramNoe       = noe_q;

endmodule

// File: tb/tb_async_ram_ctrl.sv
// tb_async_ram_ctrl: bench for async_ram_ctrl with two instances, one at
// default timing and one at SETUP=2, WRITE_PULSE=3, HOLD=2, READ_WAIT=4,
// each attached to its own behavioural asynchronous RAM.
module tb_async_ram_ctrl;

`ifdef ASYNC_RAM_CTRL_REQ_BUF_EN
    localparam bit BUF = 1'b1;
`else
    localparam bit BUF = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        req_v;
    logic        we_v;
    logic [15:0] addr_v;
    logic [15:0] wdata_v;
    int          sel;
    int          vectors;
    int          miscompares;

    logic [15:0] mem0 [65536];
    logic [15:0] mem1 [65536];
    logic [15:0] refm [int];

    async_ram_ctrl_if bus0 ();
    async_ram_ctrl_if bus1 ();

    async_ram_ctrl dut0 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus0.slave)
    );

    async_ram_ctrl #(
        .SETUP_CYCLES       (2),
        .WRITE_PULSE_CYCLES (3),
        .HOLD_CYCLES        (2),
        .READ_WAIT_CYCLES   (4)
    ) dut1 (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus1.slave)
    );

    assign bus0.i_req   = req_v && (sel == 0);
    assign bus0.i_we    = we_v;
    assign bus0.i_addr  = addr_v;
    assign bus0.i_wdata = wdata_v;
    assign bus1.i_req   = req_v && (sel == 1);
    assign bus1.i_we    = we_v;
    assign bus1.i_addr  = addr_v;
    assign bus1.i_wdata = wdata_v;

    // Asynchronous RAMs: the word is written while write enable is low,
    // read data is driven only while output enable is low.
    assign bus0.i_ramReadData = bus0.o_ramNoe ? 16'hDEAD : mem0[bus0.o_ramAddress];
    assign bus1.i_ramReadData = bus1.o_ramNoe ? 16'hDEAD : mem1[bus1.o_ramAddress];

    always @(posedge clk) begin
        if (!bus0.o_ramWriteNEn) mem0[bus0.o_ramAddress] <= bus0.o_ramWriteData;
        if (!bus1.o_ramWriteNEn) mem1[bus1.o_ramAddress] <= bus1.o_ramWriteData;
    end

    wire        obs_ready = (sel == 1) ? bus1.o_ready        : bus0.o_ready;
    wire [15:0] obs_rdata = (sel == 1) ? bus1.o_rdata        : bus0.o_rdata;
    wire        obs_rval  = (sel == 1) ? bus1.o_rvalid       : bus0.o_rvalid;
    wire        obs_wdone = (sel == 1) ? bus1.o_wdone        : bus0.o_wdone;
    wire [15:0] obs_addr  = (sel == 1) ? bus1.o_ramAddress   : bus0.o_ramAddress;
    wire        obs_wen   = (sel == 1) ? bus1.o_ramWriteNEn  : bus0.o_ramWriteNEn;
    wire [15:0] obs_wdata = (sel == 1) ? bus1.o_ramWriteData : bus0.o_ramWriteData;
    wire        obs_noe   = (sel == 1) ? bus1.o_ramNoe       : bus0.o_ramNoe;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_setup();
        return (sel == 1) ? 2 : 1;
    endfunction
    function automatic int p_pulse();
        return (sel == 1) ? 3 : 1;
    endfunction
    function automatic int p_hold();
        return (sel == 1) ? 2 : 1;
    endfunction
    function automatic int p_rwait();
        return (sel == 1) ? 4 : 2;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (obs_ready !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (obs_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout inst=%0d got=%b exp=1", sel, obs_ready);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            #0;
            vectors += 8;
            if (obs_wen !== 1'b1) begin miscompares++; $display("FAIL rst_wen inst=%0d got=%b exp=1", i, obs_wen); end
            if (obs_noe !== 1'b1) begin miscompares++; $display("FAIL rst_noe inst=%0d got=%b exp=1", i, obs_noe); end
            if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready inst=%0d got=%b exp=1", i, obs_ready); end
            if (obs_rval !== 1'b0) begin miscompares++; $display("FAIL rst_rvalid inst=%0d got=%b exp=0", i, obs_rval); end
            if (obs_wdone !== 1'b0) begin miscompares++; $display("FAIL rst_wdone inst=%0d got=%b exp=0", i, obs_wdone); end
            if (obs_addr !== 16'h0000) begin miscompares++; $display("FAIL rst_addr inst=%0d got=%h exp=0000", i, obs_addr); end
            if (obs_wdata !== 16'h0000) begin miscompares++; $display("FAIL rst_wdata inst=%0d got=%h exp=0000", i, obs_wdata); end
            if (obs_rdata !== 16'h0000) begin miscompares++; $display("FAIL rst_rdata inst=%0d got=%h exp=0000", i, obs_rdata); end
        end
        sel = 0;
    endtask

    // One write on instance sel, checked cycle by cycle from the accept edge.
    task automatic test_write_cmd(input logic [15:0] a, input logic [15:0] d);
        int s = p_setup();
        int p = p_pulse();
        int tot = p_setup() + p_pulse() + p_hold();
        logic    exp_wen;
        logic    exp_rdy;
        logic [15:0] ramv;
        wait_ready();
        @(negedge clk);
        req_v = 1'b1; we_v = 1'b1; addr_v = a; wdata_v = d;
        @(posedge clk); #1;
        req_v = 1'b0; we_v = 1'($urandom); addr_v = 16'($urandom); wdata_v = 16'($urandom);
        refm[sel * 65536 + int'(a)] = d;
        for (int k = 0; k <= tot; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_wen = !(k >= s && k < s + p);
            exp_rdy = BUF ? 1'b1 : (k == tot);
            vectors += 6;
            if (obs_wen !== exp_wen) begin miscompares++; $display("FAIL wr_wen inst=%0d k=%0d got=%b exp=%b", sel, k, obs_wen, exp_wen); end
            if (obs_noe !== 1'b1) begin miscompares++; $display("FAIL wr_noe inst=%0d k=%0d got=%b exp=1", sel, k, obs_noe); end
            if (obs_wdone !== (k == tot)) begin miscompares++; $display("FAIL wr_wdone inst=%0d k=%0d got=%b exp=%b", sel, k, obs_wdone, (k == tot)); end
            if (obs_ready !== exp_rdy) begin miscompares++; $display("FAIL wr_ready inst=%0d k=%0d got=%b exp=%b", sel, k, obs_ready, exp_rdy); end
            if (obs_addr !== a) begin miscompares++; $display("FAIL wr_addr inst=%0d k=%0d got=%h exp=%h", sel, k, obs_addr, a); end
            if (obs_wdata !== d) begin miscompares++; $display("FAIL wr_data inst=%0d k=%0d got=%h exp=%h", sel, k, obs_wdata, d); end
        end
        ramv = (sel == 1) ? mem1[a] : mem0[a];
        vectors++;
        if (ramv !== d) begin miscompares++; $display("FAIL wr_ram inst=%0d addr=%h got=%h exp=%h", sel, a, ramv, d); end
    endtask

    // One read on instance sel; expected data comes from the reference map.
    task automatic test_read_cmd(input logic [15:0] a);
        int r = p_rwait();
        int key = sel * 65536 + int'(a);
        logic [15:0] exp_d;
        logic        exp_rdy;
        exp_d = refm.exists(key) ? refm[key] : 16'h0000;
        wait_ready();
        @(negedge clk);
        req_v = 1'b1; we_v = 1'b0; addr_v = a; wdata_v = 16'($urandom);
        @(posedge clk); #1;
        req_v = 1'b0; we_v = 1'($urandom); addr_v = 16'($urandom);
        for (int k = 0; k <= r; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_rdy = BUF ? 1'b1 : (k == r);
            vectors += 5;
            if (obs_noe !== !(k < r)) begin miscompares++; $display("FAIL rd_noe inst=%0d k=%0d got=%b exp=%b", sel, k, obs_noe, !(k < r)); end
            if (obs_wen !== 1'b1) begin miscompares++; $display("FAIL rd_wen inst=%0d k=%0d got=%b exp=1", sel, k, obs_wen); end
            if (obs_rval !== (k == r)) begin miscompares++; $display("FAIL rd_rvalid inst=%0d k=%0d got=%b exp=%b", sel, k, obs_rval, (k == r)); end
            if (obs_ready !== exp_rdy) begin miscompares++; $display("FAIL rd_ready inst=%0d k=%0d got=%b exp=%b", sel, k, obs_ready, exp_rdy); end
            if (obs_addr !== a) begin miscompares++; $display("FAIL rd_addr inst=%0d k=%0d got=%h exp=%h", sel, k, obs_addr, a); end
        end
        vectors++;
        if (obs_rdata !== exp_d) begin miscompares++; $display("FAIL rd_data inst=%0d addr=%h got=%h exp=%h", sel, a, obs_rdata, exp_d); end
    endtask

    task automatic test_default_rw();
        sel = 0;
        test_write_cmd(16'h1234, 16'hBEEF);
        test_read_cmd(16'h1234);
    endtask

    task automatic test_override();
        sel = 1;
        test_write_cmd(16'h1234, 16'hBEEF);
        test_read_cmd(16'h1234);
        test_write_cmd(16'hFFFF, 16'h0000);
        test_read_cmd(16'hFFFF);
        sel = 0;
    endtask

    task automatic test_reset_abort();
        int s;
        sel = 0;
        s = p_setup();
        wait_ready();
        @(negedge clk);
        req_v = 1'b1; we_v = 1'b1; addr_v = 16'h0010; wdata_v = 16'h5555;
        @(posedge clk); #1;
        req_v = 1'b0;
        for (int k = 1; k <= s; k++) begin @(posedge clk); #1; end
        vectors++;
        if (obs_wen !== 1'b0) begin miscompares++; $display("FAIL abort_in_pulse got=%b exp=0", obs_wen); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        vectors += 5;
        if (obs_wen !== 1'b1) begin miscompares++; $display("FAIL abort_wen got=%b exp=1", obs_wen); end
        if (obs_noe !== 1'b1) begin miscompares++; $display("FAIL abort_noe got=%b exp=1", obs_noe); end
        if (obs_wdone !== 1'b0) begin miscompares++; $display("FAIL abort_wdone got=%b exp=0", obs_wdone); end
        if (obs_rval !== 1'b0) begin miscompares++; $display("FAIL abort_rvalid got=%b exp=0", obs_rval); end
        if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got=%b exp=1", obs_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        vectors += 3;
        if (obs_wdone !== 1'b0) begin miscompares++; $display("FAIL abort_wdone2 got=%b exp=0", obs_wdone); end
        if (obs_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready2 got=%b exp=1", obs_ready); end
        if (obs_wen !== 1'b1) begin miscompares++; $display("FAIL abort_wen2 got=%b exp=1", obs_wen); end
        // The aborted word is undefined; the read must return whatever the RAM holds.
        refm[16'h0010] = mem0[16'h0010];
        test_read_cmd(16'h0010);
    endtask

    task automatic test_back_to_back();
        int acc_k   = BUF ? 1 : 4;
        int rstart  = BUF ? 3 : 4;
        int rv_k    = rstart + 2;
        logic exp_rdy;
        sel = 0;
        wait_ready();
        @(negedge clk);
        req_v = 1'b1; we_v = 1'b1; addr_v = 16'h0002; wdata_v = 16'h0001;
        @(posedge clk); #1;
        we_v = 1'b0; addr_v = 16'h0002; wdata_v = 16'hAAAA;
        refm[16'h0002] = 16'h0001;
        for (int k = 0; k <= rv_k + 1; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            exp_rdy = BUF ? ((k == 0) || (k >= 3)) : ((k == 3) || (k >= rv_k));
            vectors += 5;
            if (obs_ready !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready k=%0d got=%b exp=%b", k, obs_ready, exp_rdy); end
            if (obs_wdone !== (k == 3)) begin miscompares++; $display("FAIL b2b_wdone k=%0d got=%b exp=%b", k, obs_wdone, (k == 3)); end
            if (obs_noe !== !(k >= rstart && k < rv_k)) begin miscompares++; $display("FAIL b2b_noe k=%0d got=%b exp=%b", k, obs_noe, !(k >= rstart && k < rv_k)); end
            if (obs_rval !== (k == rv_k)) begin miscompares++; $display("FAIL b2b_rvalid k=%0d got=%b exp=%b", k, obs_rval, (k == rv_k)); end
            if (obs_wen === 1'b0 && obs_noe === 1'b0) begin miscompares++; $display("FAIL b2b_excl k=%0d got=both_low exp=not_both_low", k); end
            if (k == rv_k) begin
                vectors++;
                if (obs_rdata !== 16'h0001) begin miscompares++; $display("FAIL b2b_rdata got=%h exp=0001", obs_rdata); end
            end
            if (k == acc_k) req_v = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [15:0] pool [6];
        pool[0] = 16'h1234; pool[1] = 16'h0010; pool[2] = 16'h0002;
        pool[3] = 16'hFFFF; pool[4] = 16'h0000; pool[5] = 16'h8000;
        for (int i = 0; i < 2; i++) begin
            sel = i;
            for (int j = 0; j < 6; j++) test_write_cmd(pool[j], 16'($urandom));
        end
        for (int n = 0; n < 30; n++) begin
            sel = int'($urandom_range(1, 0));
            if ($urandom_range(1, 0) == 1)
                test_write_cmd(pool[$urandom_range(5, 0)], 16'($urandom));
            else
                test_read_cmd(pool[$urandom_range(5, 0)]);
        end
        sel = 0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        sel     = 0;
        rst     = 1'b1;
        req_v   = 1'b0;
        we_v    = 1'b0;
        addr_v  = 16'h0000;
        wdata_v = 16'h0000;
        test_reset();
        test_default_rw();
        test_override();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
